data_mem_arb: RTL and testbench

DATA_MEM_ARB -- requirements
Module: data_mem_arb

---
 rtl/data_mem_arb_if.sv | 44 ++++
 rtl/data_mem_arb.sv | 141 ++++++++++++++
 tb/tb_data_mem_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arb_if.sv
// rtl/data_mem_arb_if.sv - CPU, DMA and data-memory port bundle for data_mem_arb.
interface data_mem_arb_if;
    logic        cpu_req;
    logic        cpu_wren;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic        cpu_err;
    logic [31:0] cpu_rdata;

    logic        dma_req;
    logic        dma_wren;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic        dma_err;
    logic [31:0] dma_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_bank;

    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata,
        input  dma_req, dma_wren, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_err, dma_rdata,
        output mem_addr, mem_wdata, mem_wren, mem_bank,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata,
        output dma_req, dma_wren, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_err, dma_rdata,
        input  mem_addr, mem_wdata, mem_wren, mem_bank,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_arb.sv
// rtl/data_mem_arb.sv - CPU/DMA arbiter for the single-port data memory.
// DATA_MEM_ARB_FAIR_EN enables the DMA starvation counter; undefined gives strict CPU priority.
module data_mem_arb #(
    parameter int unsigned DEPTH_WORDS  = 49152,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    state_t      r_state;
    logic        r_win_dma;
    logic        r_is_read;
    logic        r_cpu_gnt, r_dma_gnt;
    logic        r_cpu_err, r_dma_err;
    logic        r_cpu_rvalid, r_dma_rvalid;
    logic [31:0] r_cpu_rdata, r_dma_rdata;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic        r_mem_wren;
    logic [1:0]  r_mem_bank;

    logic        w_any_req;
    logic        w_fair_turn;
    logic        w_pick_dma;
    logic        w_wren;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_in_range;

    assign w_any_req  = bus.cpu_req | bus.dma_req;
    assign w_pick_dma = bus.dma_req & (~bus.cpu_req | w_fair_turn);
    assign w_wren     = w_pick_dma ? bus.dma_wren  : bus.cpu_wren;
    assign w_addr     = w_pick_dma ? bus.dma_addr  : bus.cpu_addr;
    assign w_wdata    = w_pick_dma ? bus.dma_wdata : bus.cpu_wdata;
    assign w_in_range = w_addr < DEPTH_WORDS;

`ifdef DATA_MEM_ARB_FAIR_EN
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve;

    assign w_fair_turn = (r_starve == CW'(STARVE_LIMIT));

    // Counts CPU wins that left a DMA request waiting; any DMA win clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (r_state == IDLE && w_any_req) begin
            if (w_pick_dma)
                r_starve <= '0;
            else if (bus.dma_req)
                r_starve <= r_starve + CW'(1);
        end
    end
`else
    assign w_fair_turn = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_win_dma    <= 1'b0;
            r_is_read    <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_dma_err    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wren   <= 1'b0;
            r_mem_bank   <= '0;
        end else begin
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_dma_err    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_mem_wren   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        // Out-of-range winners still pass through ACCESS so the
                        // single gnt/err pulse is seen before re-arbitration.
                        r_win_dma   <= w_pick_dma;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_mem_bank  <= w_addr[15:14];
                        r_cpu_gnt   <= ~w_pick_dma;
                        r_dma_gnt   <= w_pick_dma;
                        r_cpu_err   <= ~w_pick_dma & ~w_in_range;
                        r_dma_err   <= w_pick_dma & ~w_in_range;
                        r_mem_wren  <= w_wren & w_in_range;
                        r_is_read   <= ~w_wren & w_in_range;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_is_read) begin
                        r_cpu_rvalid <= ~r_win_dma;
                        r_dma_rvalid <= r_win_dma;
                        r_state      <= RDATA;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RDATA: begin
                    if (r_win_dma)
                        r_dma_rdata <= bus.mem_rdata;
                    else
                        r_cpu_rdata <= bus.mem_rdata;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory data only exists during RDATA, so it is forwarded then and held afterwards.
    assign bus.cpu_rdata  = (r_state == RDATA && !r_win_dma) ? bus.mem_rdata : r_cpu_rdata;
    assign bus.dma_rdata  = (r_state == RDATA &&  r_win_dma) ? bus.mem_rdata : r_dma_rdata;
    assign bus.cpu_gnt    = r_cpu_gnt;
    assign bus.dma_gnt    = r_dma_gnt;
    assign bus.cpu_err    = r_cpu_err;
    assign bus.dma_err    = r_dma_err;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.dma_rvalid = r_dma_rvalid;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wren   = r_mem_wren;
    assign bus.mem_bank   = r_mem_bank;
endmodule

// File: tb/tb_data_mem_arb.sv
// tb/tb_data_mem_arb.sv - scoreboard bench for data_mem_arb.
module tb_data_mem_arb;
    localparam int DEPTH = 49152;

    logic clk;
    logic rst;
    data_mem_arb_if bus ();

    data_mem_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Synchronous data memory model: read data one cycle after the address.
    logic [31:0] mem [0:DEPTH-1];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i) ^ 32'h8004;
    always @(posedge clk) begin
        if (bus.mem_wren === 1'b1 && bus.mem_addr < DEPTH)
            mem[bus.mem_addr[15:0]] <= bus.mem_wdata;
        bus.mem_rdata <= (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[15:0]] : 32'h0;
    end

    typedef struct {
        bit          is_dma;
        bit          wren;
        bit          err;
        bit          abort;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] sb_mem [int];

    task automatic push_exp(input bit is_dma, input bit wren, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit abort);
        exp_t e;
        e.is_dma = is_dma;
        e.wren   = wren;
        e.err    = (addr >= DEPTH);
        e.abort  = abort;
        e.addr   = addr;
        e.wdata  = wdata;
        if (!e.err && wren) sb_mem[int'(addr)] = wdata;
        e.rdata  = sb_mem.exists(int'(addr)) ? sb_mem[int'(addr)] : (addr ^ 32'h8004);
        exp_q.push_back(e);
    endtask

    bit          pend_rd = 0, pend_dma = 0, pend_abort = 0, pend_wr = 0;
    logic [31:0] pend_data = '0;

    always @(negedge clk) begin
        exp_t e;
        if (pend_wr) begin
            pend_wr = 0;
            check("wren_one_cycle", bus.mem_wren, 0);
        end
        if (pend_rd) begin
            pend_rd = 0;
            if (pend_abort) begin
                check("abort_no_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
            end else begin
                check("rvalid", pend_dma ? bus.dma_rvalid : bus.cpu_rvalid, 1);
                check("other_rvalid", pend_dma ? bus.cpu_rvalid : bus.dma_rvalid, 0);
                check("rdata", pend_dma ? bus.dma_rdata : bus.cpu_rdata, pend_data);
            end
        end else if (bus.cpu_rvalid === 1'b1 || bus.dma_rvalid === 1'b1) begin
            check("spurious_rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 0);
        end
        if (bus.cpu_gnt === 1'b1 || bus.dma_gnt === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_gnt", {bus.cpu_gnt, bus.dma_gnt}, 0);
            end else begin
                e = exp_q.pop_front();
                check("gnt_dma", bus.dma_gnt, e.is_dma);
                check("gnt_cpu", bus.cpu_gnt, !e.is_dma);
                check("err", e.is_dma ? bus.dma_err : bus.cpu_err, e.err);
                check("other_err", e.is_dma ? bus.cpu_err : bus.dma_err, 0);
                check("mem_wren", bus.mem_wren, e.wren && !e.err);
                if (!e.err) begin
                    check("mem_addr", bus.mem_addr, e.addr);
                    check("mem_bank", bus.mem_bank, e.addr[15:14]);
                    if (e.wren) begin
                        check("mem_wdata", bus.mem_wdata, e.wdata);
                        pend_wr = 1;
                    end else begin
                        pend_rd    = 1;
                        pend_dma   = e.is_dma;
                        pend_abort = e.abort;
                        pend_data  = e.rdata;
                    end
                end
            end
        end else if (bus.mem_wren === 1'b1) begin
            check("wren_without_gnt", bus.mem_wren, 0);
        end
    end

    // Raise a request, hold it until the grant is seen, then drop it.
    task automatic req_access(input bit is_dma, input bit wren, input logic [31:0] addr,
                              input logic [31:0] wdata);
        bit got;
        got = 0;
        if (is_dma) begin
            bus.dma_req = 1; bus.dma_wren = wren; bus.dma_addr = addr; bus.dma_wdata = wdata;
        end else begin
            bus.cpu_req = 1; bus.cpu_wren = wren; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge clk);
            #1;
            got = is_dma ? bus.dma_gnt : bus.cpu_gnt;
        end
        if (!got) check(is_dma ? "dma_gnt_timeout" : "cpu_gnt_timeout",
                        is_dma ? bus.dma_gnt : bus.cpu_gnt, 1);
        if (is_dma) bus.dma_req = 0;
        else        bus.cpu_req = 0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        bus.cpu_req = 0; bus.cpu_wren = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_wren = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_gnt", bus.cpu_gnt, 0);
        check("rst_dma_gnt", bus.dma_gnt, 0);
        check("rst_cpu_err", bus.cpu_err, 0);
        check("rst_dma_err", bus.dma_err, 0);
        check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        check("rst_dma_rvalid", bus.dma_rvalid, 0);
        check("rst_mem_wren", bus.mem_wren, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_bank", bus.mem_bank, 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_dma_rdata", bus.dma_rdata, 0);
        rst = 0;
        settle();

        push_exp(0, 1, 32'd16393, 32'h2, 0);
        req_access(0, 1, 32'd16393, 32'h2);
        settle();

        push_exp(1, 0, 32'd32768, '0, 0);
        req_access(1, 0, 32'd32768, '0);
        settle();

        push_exp(0, 1, 32'd7, 32'hAAAA_0007, 0);
        push_exp(1, 1, 32'd9, 32'hBBBB_0009, 0);
        fork
            req_access(0, 1, 32'd7, 32'hAAAA_0007);
            req_access(1, 1, 32'd9, 32'hBBBB_0009);
        join
        settle();

        push_exp(0, 0, 32'd49152, '0, 0);
        req_access(0, 0, 32'd49152, '0);
        settle();
        push_exp(1, 1, 32'hFFFF_FFFF, 32'h1, 0);
        req_access(1, 1, 32'hFFFF_FFFF, 32'h1);
        settle();
        push_exp(0, 0, 32'd49151, '0, 0);
        req_access(0, 0, 32'd49151, '0);
        push_exp(1, 0, 32'd16393, '0, 0);
        req_access(1, 0, 32'd16393, '0);
        push_exp(0, 0, 32'd7, '0, 0);
        req_access(0, 0, 32'd7, '0);
        settle();

        push_exp(0, 0, 32'd5, '0, 1);
        req_access(0, 0, 32'd5, '0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        push_exp(0, 0, 32'd9, '0, 0);
        req_access(0, 0, 32'd9, '0);
        settle();

        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        settle();
`ifdef DATA_MEM_ARB_FAIR_EN
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) push_exp(0, 1, 32'(100 + k * 8 + i), 32'(k * 8 + i), 0);
            push_exp(1, 1, 32'(200 + k), 32'(1000 + k), 0);
        end
        for (int i = 16; i < 18; i++) push_exp(0, 1, 32'(100 + i), 32'(i), 0);
`else
        for (int i = 0; i < 18; i++) push_exp(0, 1, 32'(100 + i), 32'(i), 0);
        for (int k = 0; k < 2; k++) push_exp(1, 1, 32'(200 + k), 32'(1000 + k), 0);
`endif
        fork
            for (int i = 0; i < 18; i++) req_access(0, 1, 32'(100 + i), 32'(i));
            for (int k = 0; k < 2; k++) req_access(1, 1, 32'(200 + k), 32'(1000 + k));
        join
        settle();

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
